pio_input_poll_sequencer: RTL and testbench

Polling sequencer that owns the 32-bit FPGA-to-HPS input PIO. It reads the PIO data register (offset 0) at a programmable period and keeps only samples that differ from the last stored one. Changed samples are queued in a small FIFO and exposed to the HPS through an Avalon-MM CSR slave with a level interrupt. Software therefore drains change events instead of busy-polling the PIO.

---
 rtl/pio_input_poll_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_pio_input_poll_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_input_poll_sequencer.sv
// Polling sequencer for a 32-bit input PIO. Reads the PIO data register at a
// fixed period, queues only changed samples in a FIFO and exposes them through
// an Avalon-MM CSR slave with a level interrupt.
// Optional feature macro: POLL_SEQ_TIMESTAMP_EN (per-entry capture timestamps).
module pio_input_poll_sequencer #(
  parameter int unsigned POLL_DIV   = 1000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  pio_address,
  input  logic [31:0] pio_readdata,
  input  logic [1:0]  csr_address,
  input  logic        csr_read,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic        irq
);

  localparam int unsigned AddrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW   = AddrW + 1;
  localparam int unsigned TimerW = 24;
  localparam logic [TimerW-1:0] TimerReload = TimerW'(POLL_DIV - 1);

  typedef enum logic [1:0] {StIdle, StAddr, StCapture, StPush} state_e;

  state_e             state_q, state_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [31:0]        sample_q, sample_d;
  logic [31:0]        last_q, last_d;
  logic               first_q, first_d;
  logic               enable_q, enable_d;
  logic               irq_en_q, irq_en_d;
  logic               force_q, force_d;
  logic               ovf_q, ovf_d;
  logic [AddrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               irq_q, irq_d;
  logic [31:0]        mem_q [FIFO_DEPTH];
  logic [31:0]        head_stamp;

  logic empty, full, pop, push_req, push, drop, ctrl_we, stat_we;

  // The PIO data register is the only one ever read.
  assign pio_address  = 2'd0;
  assign csr_readdata = rdata_q;
  assign irq          = irq_q;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(FIFO_DEPTH));
  assign pop      = csr_read && (csr_address == 2'd0) && !empty;
  assign push_req = (state_q == StPush) && enable_q &&
                    ((sample_q != last_q) || first_q || force_q);
  // A full FIFO still accepts the sample when a pop frees a slot this cycle.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && !push;
  assign ctrl_we  = csr_write && (csr_address == 2'd2);
  assign stat_we  = csr_write && (csr_address == 2'd1);

  logic unused_wdata;
  assign unused_wdata = ^{csr_writedata[31:9], csr_writedata[7:3]};

  // Poll FSM and period timer; the timer runs through the whole poll so that
  // poll starts are exactly POLL_DIV cycles apart.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (!enable_q) begin
      state_d = StIdle;
      timer_d = TimerReload;
    end else begin
      timer_d = (timer_q == '0) ? TimerReload : timer_q - TimerW'(1);
      unique case (state_q)
        StIdle:    if (timer_q == '0) state_d = StAddr;
        StAddr:    state_d = StCapture;
        StCapture: state_d = StPush;
        StPush:    state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  // Datapath, FIFO bookkeeping, CSR side effects and registered read data.
  always_comb begin
    sample_d = sample_q;
    last_d   = last_q;
    first_d  = first_q;
    enable_d = enable_q;
    irq_en_d = irq_en_q;
    force_d  = force_q;
    ovf_d    = ovf_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    irq_d    = irq_en_q & (!empty | ovf_q);

    if (state_q == StCapture) sample_d = pio_readdata;

    if (push) begin
      last_d   = sample_q;
      first_d  = 1'b0;
      force_d  = 1'b0;
      wr_ptr_d = wr_ptr_q + AddrW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AddrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear leaves overflow set.
    if (stat_we && csr_writedata[8]) ovf_d = 1'b0;
    if (drop) ovf_d = 1'b1;

    if (ctrl_we) begin
      enable_d = csr_writedata[0];
      irq_en_d = csr_writedata[1];
      force_d  = csr_writedata[2];
      if (csr_writedata[0] && !enable_q) first_d = 1'b1;
    end

    if (csr_read) begin
      unique case (csr_address)
        2'd0: rdata_d = empty ? 32'd0 : mem_q[rd_ptr_q];
        2'd1: rdata_d = {8'd0, 8'(count_q), 7'd0, ovf_q, 6'd0, full, empty};
        2'd2: rdata_d = {29'd0, force_q, irq_en_q, enable_q};
        2'd3: rdata_d = head_stamp;
        default: rdata_d = 32'd0;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      timer_q  <= TimerReload;
      sample_q <= '0;
      last_q   <= '0;
      first_q  <= 1'b1;
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      force_q  <= 1'b0;
      ovf_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      sample_q <= sample_d;
      last_q   <= last_d;
      first_q  <= first_d;
      enable_q <= enable_d;
      irq_en_q <= irq_en_d;
      force_q  <= force_d;
      ovf_q    <= ovf_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sample_q;
  end

`ifdef POLL_SEQ_TIMESTAMP_EN
  logic [31:0] cyc_q, stamp_q;
  logic [31:0] stamp_mem_q [FIFO_DEPTH];

  // Free-running cycle counter and the stamp of the sample being captured.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cyc_q   <= '0;
      stamp_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (state_q == StCapture) stamp_q <= cyc_q;
    end
  end

  // Stamp storage alongside each FIFO entry.
  always_ff @(posedge clk) begin
    if (push) stamp_mem_q[wr_ptr_q] <= stamp_q;
  end

  assign head_stamp = empty ? 32'd0 : stamp_mem_q[rd_ptr_q];
`else
  assign head_stamp = 32'd0;
`endif

endmodule

// File: tb/tb_pio_input_poll_sequencer.sv
// Self-checking bench for pio_input_poll_sequencer (POLL_DIV=8, FIFO_DEPTH=4).
// Directed table, hand-written corner sequences, then randomized polls checked
// against a queue-based model of the change-capture rules.
module tb_pio_input_poll_sequencer;
  localparam int unsigned PollDiv = 8;
  localparam int unsigned Depth   = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  pio_address;
  logic [31:0] pio_readdata;
  logic [31:0] in_port;
  logic [1:0]  csr_address;
  logic        csr_read, csr_write;
  logic [31:0] csr_writedata, csr_readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] in_val;
    logic [1:0]  addr;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;
  vec_t vecs [12];

  // Reference model state
  logic [31:0] mq [$];
  logic [31:0] m_last;
  bit          m_first, m_force, m_ovf;

  logic [31:0] rd, t1, t2, lastval, v, exp;

  always #5 clk = ~clk;

  // PIO slave: registered read of the input port
  always @(posedge clk) pio_readdata <= in_port;

  pio_input_poll_sequencer #(.POLL_DIV(PollDiv), .FIFO_DEPTH(Depth)) dut (
    .clk(clk), .reset_n(reset_n), .pio_address(pio_address), .pio_readdata(pio_readdata),
    .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata), .irq(irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    csr_address = a;
    csr_read    = 1'b1;
    tick();
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] expv);
    logic [31:0] d;
    csr_rd(a, d);
    chk(name, d, expv);
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    csr_address   = a;
    csr_writedata = d;
    csr_write     = 1'b1;
    tick();
    csr_write = 1'b0;
  endtask

  // One full poll period starting 4 cycles after a timer expiry; the new value
  // is what the next poll captures.
  task automatic period_hold(input logic [31:0] val);
    in_port = val;
    ticks(8);
  endtask

  // Model: one poll of value val
  task automatic model_poll(input logic [31:0] val);
    if (val != m_last || m_first || m_force) begin
      if (mq.size() < Depth) begin
        mq.push_back(val);
        m_last  = val;
        m_first = 1'b0;
        m_force = 1'b0;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [7:0] cnt;
    cnt = 8'(mq.size());
    return {8'd0, cnt, 7'd0, m_ovf, 6'd0, mq.size() == Depth, mq.size() == 0};
  endfunction

  // Randomized poll period: irq check, up to three random CSR ops, then poll.
  task automatic rperiod(input int idx);
    int op;
    bit f;
    v = 32'($urandom_range(0, 3));
    in_port = v;
    tick();
    chk($sformatf("rnd%0d_irq", idx), {31'd0, irq}, {31'd0, (mq.size() != 0) || m_ovf});
    for (int k = 0; k < 3; k++) begin
      op = $urandom_range(0, 5);
      case (op)
        0, 1: begin
          exp = (mq.size() != 0) ? mq.pop_front() : 32'd0;
          rd_chk($sformatf("rnd%0d_data", idx), 2'd0, exp);
        end
        2: rd_chk($sformatf("rnd%0d_status", idx), 2'd1, model_status());
        3: begin
          f = 1'($urandom_range(0, 1));
          csr_wr(2'd1, {23'd0, f, 8'd0});
          if (f) m_ovf = 1'b0;
        end
        4: begin
          f = 1'($urandom_range(0, 1));
          csr_wr(2'd2, {29'd0, f, 2'b11});
          m_force = f;
        end
        default: tick();
      endcase
    end
    ticks(4);
    model_poll(v);
  endtask

  initial begin
    vecs[0]  = '{32'hA5, 2'd1, 32'h0001_0000, 1'b1};
    vecs[1]  = '{32'hA5, 2'd0, 32'h0000_00A5, 1'b1};
    vecs[2]  = '{32'hA5, 2'd1, 32'h0000_0001, 1'b0};
    vecs[3]  = '{32'h01, 2'd1, 32'h0000_0001, 1'b0};
    vecs[4]  = '{32'h02, 2'd1, 32'h0001_0000, 1'b1};
    vecs[5]  = '{32'h01, 2'd1, 32'h0002_0000, 1'b1};
    vecs[6]  = '{32'h01, 2'd0, 32'h0000_0001, 1'b1};
    vecs[7]  = '{32'h01, 2'd0, 32'h0000_0002, 1'b1};
    vecs[8]  = '{32'h01, 2'd0, 32'h0000_0001, 1'b1};
    vecs[9]  = '{32'h01, 2'd0, 32'h0000_0000, 1'b0};
    vecs[10] = '{32'h01, 2'd3, 32'h0000_0000, 1'b0};
    vecs[11] = '{32'h01, 2'd2, 32'h0000_0003, 1'b0};

    reset_n = 1'b0;
    in_port = 32'd0;
    csr_address = 2'd0;
    csr_read = 1'b0;
    csr_write = 1'b0;
    csr_writedata = 32'd0;
    ticks(2);
    chk("rst_readdata", csr_readdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_pio_addr", {30'd0, pio_address}, 32'd0);
    reset_n = 1'b1;
    rd_chk("rst_status", 2'd1, 32'h1);
    rd_chk("rst_control", 2'd2, 32'h0);

    // Enable; first poll captures 8 cycles later and is visible 11 cycles later
    in_port = 32'hA5;
    csr_wr(2'd2, 32'h3);
    ticks(11);

    // Table: per period check irq, one CSR read, then let the next poll run
    for (int i = 0; i < 12; i++) begin
      in_port = vecs[i].in_val;
      tick();
      chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
      rd_chk($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp_rd);
      ticks(6);
    end

    // Overflow: six changes with no reads into a 4-deep FIFO
    for (int i = 0; i < 6; i++) period_hold(32'h10 + 32'(i));
    in_port = 32'h13;
    tick();
    chk("ovf_irq", {31'd0, irq}, 32'd1);
    rd_chk("ovf_status", 2'd1, 32'h0004_0102);
    csr_wr(2'd1, 32'h100);
    rd_chk("ovf_cleared", 2'd1, 32'h0004_0002);
    tick();
    chk("ovf_irq_held", {31'd0, irq}, 32'd1);
    ticks(3);

    // Pop in the same cycle as a push into a full FIFO
    in_port = 32'h16;
    ticks(7);
    rd_chk("popush_data", 2'd0, 32'h10);
    tick();
    rd_chk("popush_status", 2'd1, 32'h0004_0002);
    ticks(6);
    rd_chk("drain0", 2'd0, 32'h11);
    rd_chk("drain1", 2'd0, 32'h12);
    rd_chk("drain2", 2'd0, 32'h13);
    rd_chk("drain3", 2'd0, 32'h16);
    tick();
    chk("drain_irq", {31'd0, irq}, 32'd0);
    ticks(3);
    lastval = 32'h16;

`ifdef POLL_SEQ_TIMESTAMP_EN
    period_hold(32'h21);
    period_hold(32'h22);
    csr_rd(2'd3, t1);
    rd_chk("ts_data0", 2'd0, 32'h21);
    csr_rd(2'd3, t2);
    rd_chk("ts_data1", 2'd0, 32'h22);
    chk("ts_delta_mod", (t2 - t1) % PollDiv, 32'd0);
    chk("ts_delta_nz", {31'd0, t2 != t1}, 32'd1);
    ticks(4);
    lastval = 32'h22;
`endif

    // Clear enable so it lands in the ADDR cycle: no push may follow
    in_port = 32'h77;
    ticks(4);
    csr_wr(2'd2, 32'h2);
    ticks(12);
    rd_chk("dis_status", 2'd1, 32'h1);
    chk("dis_irq", {31'd0, irq}, 32'd0);
    // Re-enable with an unchanged input: the first poll still pushes
    in_port = lastval;
    csr_wr(2'd2, 32'h3);
    ticks(11);
    rd_chk("reen_status", 2'd1, 32'h0001_0000);
    rd_chk("reen_data", 2'd0, lastval);
    ticks(6);

    // Reset asserted during CAPTURE
    in_port = 32'h55;
    ticks(6);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_readdata", csr_readdata, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    rd_chk("mid_rst_control", 2'd2, 32'h0);
    ticks(20);
    rd_chk("mid_rst_status", 2'd1, 32'h1);

    // Randomized polling against the model
    mq.delete();
    m_last  = 32'd0;
    m_first = 1'b1;
    m_force = 1'b0;
    m_ovf   = 1'b0;
    v = 32'($urandom_range(0, 3));
    in_port = v;
    csr_wr(2'd2, 32'h3);
    ticks(11);
    model_poll(v);
    for (int i = 0; i < 60; i++) rperiod(i);
    rd_chk("rnd_final_status", 2'd1, model_status());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
